uart_tx: RTL and testbench

Serial UART transmitter for the krv_e SoC UART block, the transmit-side counterpart of `uart_rx`. It accepts bytes written by the APB register interface, serialises them LSB-first as start / data / optional parity / stop frames on `UART_TX`, and uses the same 16x oversampling pulse and line-format controls as the receiver, so a `uart_tx` → `uart_rx` loopback is bit-exact.

---
 rtl/uart_tx.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 16x-oversampled start/data/parity/stop framing, LSB first.
// Define KRV_UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       tx_sample_pulse,
  input  logic       data_bits,
  input  logic       parity_en,
  input  logic       parity_odd0_even1,
  input  logic       tx_data_reg_wr,
  input  logic [7:0] tx_data,
  output logic       UART_TX,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overflow
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            db_q, db_d;
  logic            pe_q, pe_d;
  logic            even_q, even_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic            buf_empty;
  logic            buf_full;
  logic [7:0]      buf_head;
  logic            pop;
  logic            push;
  logic            bit_end;
  logic            load_frame;

  assign push = tx_data_reg_wr && (!buf_full || pop);

`ifdef KRV_UART_TX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  assign buf_empty = (wptr_q == rptr_q);
  assign buf_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign buf_head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= tx_data;
  end
`else
  logic       hold_valid_q;
  logic [7:0] hold_data_q;

  assign buf_empty = !hold_valid_q;
  assign buf_full  = hold_valid_q;
  assign buf_head  = hold_data_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= tx_data;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  assign bit_end = tx_sample_pulse && (cnt_q == CW'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    db_d       = db_q;
    pe_d       = pe_q;
    even_d     = even_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    load_frame = 1'b0;
    tx_d       = 1'b1;

    if (state_q != IDLE && tx_sample_pulse) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (!buf_empty) load_frame = 1'b1;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          par_d   = par_q ^ shift_q[0];
          idx_d   = idx_q + 3'd1;
          if (idx_q == (db_q ? 3'd7 : 3'd6)) state_d = pe_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Pending data starts its START directly from the stop-bit end, so no idle gap.
        if (bit_end) begin
          done_d = 1'b1;
          if (!buf_empty) load_frame = 1'b1;
          else            state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_frame) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      par_d   = 1'b0;
      shift_d = buf_head;
      db_d    = data_bits;
      pe_d    = parity_en;
      even_d  = parity_odd0_even1;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ ~even_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign ovf_d = tx_data_reg_wr && !push;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      db_q    <= 1'b1;
      pe_q    <= 1'b0;
      even_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      db_q    <= db_d;
      pe_q    <= pe_d;
      even_q  <= even_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign UART_TX     = tx_q;
  assign tx_ready    = !buf_full;
  assign tx_busy     = (state_q != IDLE) || !buf_empty;
  assign tx_done     = done_q;
  assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fixed frame table, timing/overflow/reset sequences, random frames.
module tb_uart_tx;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic       tx_sample_pulse = 1'b0;
  logic       data_bits = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd0_even1 = 1'b1;
  logic       tx_data_reg_wr = 1'b0;
  logic [7:0] tx_data = '0;
  logic       UART_TX;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_overflow;

  int checks = 0;
  int failures = 0;
  int pulse_period = 4;
  int done_cnt = 0;
  int ovf_cnt = 0;
  int cyc = 0;

  uart_tx #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .ACLK              (ACLK),
    .ARESETn           (ARESETn),
    .tx_sample_pulse   (tx_sample_pulse),
    .data_bits         (data_bits),
    .parity_en         (parity_en),
    .parity_odd0_even1 (parity_odd0_even1),
    .tx_data_reg_wr    (tx_data_reg_wr),
    .tx_data           (tx_data),
    .UART_TX           (UART_TX),
    .tx_ready          (tx_ready),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_overflow       (tx_overflow)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    forever begin
      repeat (pulse_period - 1) @(posedge ACLK);
      #1 tx_sample_pulse = 1'b1;
      @(posedge ACLK);
      #1 tx_sample_pulse = 1'b0;
    end
  end

  always @(negedge ACLK) begin
    cyc++;
    if (tx_done) done_cnt++;
    if (tx_overflow) ovf_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected frame from the line rules: start 0, n data bits LSB first, parity over sent bits, stop 1.
  function automatic void model(input logic [7:0] d, input logic db, input logic pe, input logic even,
                                output int len, output logic [11:0] fr);
    int n;
    int ones;
    n = db ? 8 : 7;
    fr = '0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      fr[1 + i] = d[i];
      ones += int'(d[i]);
    end
    len = n + 1;
    if (pe) begin
      fr[len] = even ? (ones % 2 == 1) : (ones % 2 == 0);
      len++;
    end
    fr[len] = 1'b1;
    len++;
  endfunction

  task automatic wr(input logic [7:0] b);
    @(posedge ACLK);
    #1 tx_data = b;
    tx_data_reg_wr = 1'b1;
    @(posedge ACLK);
    #1 tx_data_reg_wr = 1'b0;
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge ACLK);
      if (UART_TX === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples each bit at its 8th pulse; returns at the negedge showing the stop-ending pulse.
  task automatic capture(input int len, input int limit, input bit scramble,
                         output logic [11:0] bits, output bit ok);
    int cnt;
    bits = '0;
    wait_start(limit, ok);
    if (!ok) return;
    if (scramble) begin
      data_bits = 1'($urandom);
      parity_en = 1'($urandom);
      parity_odd0_even1 = 1'($urandom);
    end
    cnt = 0;
    forever begin
      if (tx_sample_pulse) begin
        cnt++;
        if (cnt % 16 == 8 && cnt / 16 < 12) bits[cnt / 16] = UART_TX;
        if (cnt == 16 * len) break;
      end
      @(negedge ACLK);
    end
  endtask

  task automatic wait_pulses(input int n);
    int cnt;
    cnt = 0;
    while (cnt < n) begin
      if (tx_sample_pulse) cnt++;
      if (cnt < n) @(negedge ACLK);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        db;
    logic        pe;
    logic        even;
    int          len;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [11:0] got;
    logic [11:0] exp_fr;
    bit          ok;
    int          len;
    int          d0;
    int          o0;
    int          edge_cyc[10];
    int          nedge;
    logic        last_tx;
    logic [7:0]  burst[$];
    int          accepted;
    logic [7:0]  rd;
    logic        rdb, rpe, rev;

    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 10, 12'h2AA};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, 12'h54A};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 12'h74A};
    vecs[3] = '{8'hC1, 1'b0, 1'b1, 1'b1, 10, 12'h282};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 10, 12'h200};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 10, 12'h2FE};
    vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b1,  9, 12'h178};
    vecs[7] = '{8'h81, 1'b1, 1'b1, 1'b1, 11, 12'h502};

    // Reset state, sampled while reset is held
    repeat (3) @(negedge ACLK);
    check("rst_tx", UART_TX, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ovf", tx_overflow, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    // Fixed frame table
    for (int v = 0; v < 8; v++) begin
      data_bits = vecs[v].db;
      parity_en = vecs[v].pe;
      parity_odd0_even1 = vecs[v].even;
      d0 = done_cnt;
      wr(vecs[v].data);
      check("ready_after_wr", tx_ready, 0);
      check("busy_after_wr", tx_busy, 1);
      capture(vecs[v].len, 50, 1'b0, got, ok);
      check("tbl_start_seen", 32'(ok), 1);
      check("tbl_frame", 32'(got), 32'(vecs[v].frame));
      repeat (3) @(negedge ACLK);
      check("tbl_done_once", 32'(done_cnt - d0), 1);
      check("tbl_busy_end", tx_busy, 0);
      check("tbl_ready_end", tx_ready, 1);
      check("tbl_idle_line", UART_TX, 1);
    end

    // 8N1 0x55: every data bit lasts exactly 64 cycles at a 4-cycle pulse period
    pulse_period = 4;
    data_bits = 1'b1;
    parity_en = 1'b0;
    repeat (8) @(negedge ACLK);
    d0 = done_cnt;
    wr(8'h55);
    wait_start(50, ok);
    check("t55_start_seen", 32'(ok), 1);
    edge_cyc[0] = cyc;
    nedge = 1;
    last_tx = 1'b0;
    for (int i = 0; i < 2000 && nedge < 10; i++) begin
      @(negedge ACLK);
      if (UART_TX !== last_tx) begin
        edge_cyc[nedge] = cyc;
        nedge++;
        last_tx = UART_TX;
      end
    end
    check("t55_edges", 32'(nedge), 10);
    check("t55_start_le64", 32'(edge_cyc[1] - edge_cyc[0] <= 64 && edge_cyc[1] - edge_cyc[0] > 56), 1);
    for (int i = 1; i < 9; i++) check("t55_bit_len", 32'(edge_cyc[i + 1] - edge_cyc[i]), 64);
    repeat (70) @(negedge ACLK);
    check("t55_done_once", 32'(done_cnt - d0), 1);
    check("t55_busy_end", tx_busy, 0);

    // Back-to-back writes past buffer capacity: one drop, remaining frames contiguous
    pulse_period = 2;
`ifdef KRV_UART_TX_FIFO_EN
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    accepted = 5;
`else
    burst = '{8'h11, 8'h22, 8'h33};
    accepted = 2;
`endif
    repeat (4) @(negedge ACLK);
    d0 = done_cnt;
    o0 = ovf_cnt;
    @(posedge ACLK);
    foreach (burst[i]) begin
      #1 tx_data = burst[i];
      tx_data_reg_wr = 1'b1;
      @(posedge ACLK);
    end
    #1 tx_data_reg_wr = 1'b0;
    for (int f = 0; f < accepted; f++) begin
      model(burst[f], 1'b1, 1'b0, 1'b1, len, exp_fr);
      capture(len, (f == 0) ? 50 : 3, 1'b0, got, ok);
      check("b2b_start_seen", 32'(ok), 1);
      check("b2b_frame", 32'(got), 32'(exp_fr));
    end
    wait_start(200, ok);
    check("b2b_no_extra_frame", 32'(ok), 0);
    check("b2b_done_count", 32'(done_cnt - d0), 32'(accepted));
    check("b2b_ovf_count", 32'(ovf_cnt - o0), 1);
    check("b2b_busy_end", tx_busy, 0);

    // Reset during DATA bit 3, then a full frame after release
    pulse_period = 4;
    data_bits = 1'b1;
    parity_en = 1'b0;
    wr(8'h00);
    wait_start(50, ok);
    check("rmid_start_seen", 32'(ok), 1);
    wait_pulses(72);
    check("rmid_bit3_low", UART_TX, 0);
    #2 ARESETn = 1'b0;
    #1;
    check("rmid_tx_async", UART_TX, 1);
    check("rmid_ready", tx_ready, 1);
    check("rmid_busy", tx_busy, 0);
    check("rmid_done", tx_done, 0);
    check("rmid_ovf", tx_overflow, 0);
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rrel_tx", UART_TX, 1);
    check("rrel_busy", tx_busy, 0);
    check("rrel_ready", tx_ready, 1);
    data_bits = 1'b1;
    parity_en = 1'b1;
    parity_odd0_even1 = 1'b1;
    d0 = done_cnt;
    wr(8'h3C);
    capture(11, 50, 1'b0, got, ok);
    check("rrel_start_seen", 32'(ok), 1);
    check("rrel_frame", 32'(got), 32'h478);
    repeat (3) @(negedge ACLK);
    check("rrel_done_once", 32'(done_cnt - d0), 1);

    // Random frames; line format is scrambled mid-frame and must not affect the frame in flight
    for (int r = 0; r < 12; r++) begin
      rd = 8'($urandom);
      rdb = 1'($urandom);
      rpe = 1'($urandom);
      rev = 1'($urandom);
      pulse_period = int'($urandom_range(5, 2));
      data_bits = rdb;
      parity_en = rpe;
      parity_odd0_even1 = rev;
      model(rd, rdb, rpe, rev, len, exp_fr);
      repeat (2) @(negedge ACLK);
      d0 = done_cnt;
      wr(rd);
      capture(len, 50, 1'b1, got, ok);
      check("rnd_start_seen", 32'(ok), 1);
      check("rnd_frame", 32'(got), 32'(exp_fr));
      repeat (3) @(negedge ACLK);
      check("rnd_done_once", 32'(done_cnt - d0), 1);
      check("rnd_busy_end", tx_busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
